// File: rtl/aq_vfmau_wb_buf.sv
`default_nettype none
// ============================================================================
//  Module   : aq_vfmau_wb_buf
//  Purpose  : Two-entry in-order writeback buffer between the vfmau result
//             stages (ex3/ex4/ex5) and the vector register file. It accepts
//             at most one result per cycle (ex5 > ex4 > ex3, oldest first)
//             and accumulates the sticky exception flags of retired entries.
//  Ports    : forever_cpuclk / cpurst_b   clock, async active-low reset
//             exN_res_vld/res/fflags/preg result inputs of stage N (3,4,5)
//             wbbuf_exN_stall             stage N result not accepted
//             wbbuf_rf_vld/data/preg      head entry toward register file
//             rf_wbbuf_ready              register file takes the head
//             cp0_vpu_fflags_clr          clear sticky flags
//             wbbuf_cp0_fflags            sticky accumulated flags
//             wbbuf_empty                 buffer holds no entries
//  Revision : 1.0  initial release
// ============================================================================
module aq_vfmau_wb_buf (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ex3_res_vld,
    input  logic [63:0] ex3_res,
    input  logic [4:0]  ex3_fflags,
    input  logic [5:0]  ex3_preg,
    input  logic        ex4_res_vld,
    input  logic [63:0] ex4_res,
    input  logic [4:0]  ex4_fflags,
    input  logic [5:0]  ex4_preg,
    input  logic        ex5_res_vld,
    input  logic [63:0] ex5_res,
    input  logic [4:0]  ex5_fflags,
    input  logic [5:0]  ex5_preg,
    output logic        wbbuf_ex3_stall,
    output logic        wbbuf_ex4_stall,
    output logic        wbbuf_ex5_stall,
    output logic        wbbuf_rf_vld,
    output logic [63:0] wbbuf_rf_data,
    output logic [5:0]  wbbuf_rf_preg,
    input  logic        rf_wbbuf_ready,
    input  logic        cp0_vpu_fflags_clr,
    output logic [4:0]  wbbuf_cp0_fflags,
    output logic        wbbuf_empty
);

    // State
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [4:0]  sticky_q, sticky_d;

    // Payload storage; no reset needed, qualified by count
    logic [63:0] data_q  [2];
    logic [5:0]  preg_q  [2];
    logic [4:0]  flags_q [2];

    // Control
    logic        pop;
    logic        push;
    logic        can_push;
    logic        any_vld;
    logic [63:0] sel_res;
    logic [5:0]  sel_preg;
    logic [4:0]  sel_fflags;

    assign wbbuf_rf_vld     = (count_q != 2'd0);
    assign wbbuf_empty      = (count_q == 2'd0);
    assign wbbuf_rf_data    = data_q[head_q];
    assign wbbuf_rf_preg    = preg_q[head_q];
    assign wbbuf_cp0_fflags = sticky_q;

    assign pop      = wbbuf_rf_vld & rf_wbbuf_ready;
    // A full buffer can still accept when the head leaves this same cycle
    assign can_push = (count_q != 2'd2) | pop;
    assign any_vld  = ex3_res_vld | ex4_res_vld | ex5_res_vld;
    assign push     = any_vld & can_push;

    // Each stage loses either to an older valid stage or to a full buffer
    assign wbbuf_ex5_stall = ex5_res_vld & ~can_push;
    assign wbbuf_ex4_stall = ex4_res_vld & (ex5_res_vld | ~can_push);
    assign wbbuf_ex3_stall = ex3_res_vld & (ex5_res_vld | ex4_res_vld | ~can_push);

    // Fixed-priority source select, oldest stage first
    always_comb begin
        sel_res    = ex3_res;
        sel_preg   = ex3_preg;
        sel_fflags = ex3_fflags;
        if (ex5_res_vld) begin
            sel_res    = ex5_res;
            sel_preg   = ex5_preg;
            sel_fflags = ex5_fflags;
        end else if (ex4_res_vld) begin
            sel_res    = ex4_res;
            sel_preg   = ex4_preg;
            sel_fflags = ex4_fflags;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        head_d = pop  ? ~head_q : head_q;
        tail_d = push ? ~tail_q : tail_q;
        // A clear coinciding with a pop keeps only the popped flags
        sticky_d = (cp0_vpu_fflags_clr ? 5'd0 : sticky_q)
                 | (pop ? flags_q[head_q] : 5'd0);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            sticky_q <= 5'd0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            data_q[tail_q]  <= sel_res;
            preg_q[tail_q]  <= sel_preg;
            flags_q[tail_q] <= sel_fflags;
        end
    end

endmodule
`default_nettype wire
